// File: rtl/jt49_dcrm_mc.sv
// rtl/jt49_dcrm_mc.sv - time-multiplexed multi-channel DC removal filter
// One shared datapath walks the channels serially after each sample strobe.
module jt49_dcrm_mc #(
    parameter int SW = 8,
    parameter int CH = 3,
    parameter int DW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [CH*SW-1:0] din,
    input  logic             sgn,
    input  logic [3:0]       kshift,
    input  logic             clr,
    output logic [CH*SW-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             overrun
);
    localparam int W = SW + DW + 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CW-1:0] LAST = CW'(CH - 1);
    localparam logic [4:0] DWK = (DW > 15) ? 5'd15 : 5'(DW);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]         cnt;
    logic [CH*SW-1:0]      din_buf, res, res_nxt;
    logic                  sgn_buf;
    logic [3:0]            k_buf, k_in;
    logic signed [W-1:0]   integ [CH];
    logic signed [W-1:0]   err   [CH];

    logic [SW-1:0]         xin, sat;
    logic [SW:0]           x, q;
    logic [SW+1:0]         p;
    logic [W-1:0]          exact, pw, integ_nxt, err_nxt;
    logic [5:0]            sh;

    // kshift of 0 acts as 1, anything past DW acts as DW
    always_comb begin
        k_in = kshift;
        if (kshift == 4'd0)
            k_in = 4'd1;
        else if ({1'b0, kshift} > DWK)
            k_in = DWK[3:0];
    end

    always_comb begin
        xin       = din_buf[cnt*SW +: SW];
        x         = sgn_buf ? {xin[SW-1], xin} : {1'b0, xin};
        exact     = integ[cnt] + err[cnt];
        q         = exact[W-1:DW];
        p         = {x[SW], x} - {q[SW], q};
        pw        = {{(DW-1){p[SW+1]}}, p};
        sh        = 6'(DW) - {2'b00, k_buf};
        integ_nxt = integ[cnt] + (pw <<< sh);
        err_nxt   = {{(W-DW){1'b0}}, exact[DW-1:0]};
        if (p[SW+1:SW-1] == 3'b000 || p[SW+1:SW-1] == 3'b111)
            sat = p[SW-1:0];
        else if (p[SW+1])
            sat = {1'b1, {(SW-1){1'b0}}};
        else
            sat = {1'b0, {(SW-1){1'b1}}};
        res_nxt = res;
        res_nxt[cnt*SW +: SW] = sat;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cen) state_nxt = RUN;
            RUN:  if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr)
            state_nxt = IDLE;
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            din_buf    <= '0;
            sgn_buf    <= 1'b0;
            k_buf      <= 4'd1;
            res        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                integ[i] <= '0;
                err[i]   <= '0;
            end
        end else begin
            state      <= state_nxt;
            dout_valid <= 1'b0;
            if (clr) begin
                cnt <= '0;
                res <= '0;
                for (int i = 0; i < CH; i++) begin
                    integ[i] <= '0;
                    err[i]   <= '0;
                end
            end else begin
                if (state == IDLE && cen) begin
                    din_buf <= din;
                    sgn_buf <= sgn;
                    k_buf   <= k_in;
                    cnt     <= '0;
                end
                if (state == RUN) begin
                    integ[cnt] <= integ_nxt;
                    err[cnt]   <= err_nxt;
                    res        <= res_nxt;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        dout       <= res_nxt;
                        dout_valid <= 1'b1;
                    end
                    // a strobe landing on a busy cycle loses its frame
                    if (cen)
                        overrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jt49_dcrm_mc.sv
// tb/tb_jt49_dcrm_mc.sv - self-checking bench for jt49_dcrm_mc
module tb_jt49_dcrm_mc;
    localparam int WB = 19;

    logic        clk, rst, cen, sgn, clr;
    logic [23:0] din;
    logic [3:0]  kshift;
    logic [23:0] dout;
    logic        dout_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    longint m_integ [3];
    longint m_err   [3];
    int     m_out   [3];
    int     got     [3];
    int     prev    [3];
    int     seq     [800];

    typedef struct {
        logic       s;
        logic [3:0] k;
        logic [7:0] d0, d1, d2;
        int         e0, e1, e2;
    } vec_t;
    vec_t vt [6];

    jt49_dcrm_mc dut (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .sgn(sgn), .kshift(kshift),
        .clr(clr), .dout(dout), .dout_valid(dout_valid), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrapw(input longint v);
        longint r;
        r = v & ((64'sd1 <<< WB) - 1);
        if (r >= (64'sd1 <<< (WB - 1)))
            r = r - (64'sd1 <<< WB);
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            m_integ[c] = 0;
            m_err[c]   = 0;
        end
    endtask

    task automatic model_frame(input logic s, input logic [3:0] k, input logic [23:0] d);
        int kk;
        logic [7:0] code;
        longint x, exact, q, p;
        kk = (k == 0) ? 1 : ((k > 10) ? 10 : int'(k));
        for (int c = 0; c < 3; c++) begin
            code  = d[c*8 +: 8];
            x     = s ? longint'($signed(code)) : longint'(code);
            exact = wrapw(m_integ[c] + m_err[c]);
            q     = exact >>> 10;
            p     = x - q;
            m_integ[c] = wrapw(m_integ[c] + p * (64'sd1 <<< (10 - kk)));
            m_err[c]   = exact - q * 1024;
            m_out[c]   = (p > 127) ? 127 : ((p < -128) ? -128 : int'(p));
        end
    endtask

    task automatic read_dout();
        logic [7:0] b;
        for (int c = 0; c < 3; c++) begin
            b = dout[c*8 +: 8];
            got[c] = int'($signed(b));
        end
    endtask

    task automatic launch(input logic s, input logic [3:0] k, input logic [23:0] d);
        @(negedge clk);
        din = d; sgn = s; kshift = k; cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
    endtask

    task automatic finish_frame(input logic s, input logic [3:0] k, input logic [23:0] d);
        int n;
        n = 0;
        while (!dout_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done", int'(dout_valid), 1);
        read_dout();
        model_frame(s, k, d);
        for (int c = 0; c < 3; c++)
            chk($sformatf("model_ch%0d", c), got[c], m_out[c]);
    endtask

    task automatic run_frame(input logic s, input logic [3:0] k, input logic [23:0] d);
        launch(s, k, d);
        finish_frame(s, k, d);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [23:0] d;
        logic [23:0] hold;
        logic        s;
        logic [3:0]  k;
        int          bad, hit;

        rst = 1'b1; cen = 1'b0; clr = 1'b0; din = '0; sgn = 1'b0; kshift = 4'd4;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        vt[0] = '{1'b0, 4'd4, 8'd200, 8'd200, 8'd200, 127, 127, 127};
        vt[1] = '{1'b1, 4'd4, 8'h80, 8'h7F, 8'h00, -128, 127, 0};
        vt[2] = '{1'b0, 4'd4, 8'h80, 8'h7F, 8'h00, 127, 127, 0};
        vt[3] = '{1'b0, 4'd4, 8'd50, 8'd50, 8'd50, 50, 50, 50};
        vt[4] = '{1'b1, 4'd4, 8'hFF, 8'h01, 8'hC0, -1, 1, -64};
        vt[5] = '{1'b0, 4'd0, 8'h00, 8'hFF, 8'h10, 0, 127, 16};
        for (int i = 0; i < 6; i++) begin
            do_clr();
            run_frame(vt[i].s, vt[i].k, {vt[i].d2, vt[i].d1, vt[i].d0});
            chk($sformatf("vec%0d_ch0", i), got[0], vt[i].e0);
            chk($sformatf("vec%0d_ch1", i), got[1], vt[i].e1);
            chk($sformatf("vec%0d_ch2", i), got[2], vt[i].e2);
        end

        // DC input of 200 decays toward zero
        do_clr();
        for (int f = 0; f < 260; f++) begin
            run_frame(1'b0, 4'd4, {8'd200, 8'd200, 8'd200});
            for (int c = 0; c < 3; c++) begin
                if (f > 0)
                    chk("decay_monotonic", int'(got[c] <= prev[c] + 1), 1);
                if (f >= 255)
                    chk("dc_settled", int'(got[c] >= -1 && got[c] <= 1), 1);
                prev[c] = got[c];
            end
        end

        // channel independence
        do_clr();
        for (int f = 0; f < 300; f++) begin
            run_frame(1'b0, 4'd4, {8'd0, 8'd0, 8'd100});
            chk("indep_ch1", got[1], 0);
            chk("indep_ch2", got[2], 0);
            if (f >= 296)
                chk("indep_ch0_settled", int'(got[0] >= -1 && got[0] <= 1), 1);
        end

        // handshake: latency, overrun at E(CH), acceptance at E(CH+1)
        chk("overrun_idle", int'(overrun), 0);
        d = 24'h123456;
        launch(1'b0, 4'd4, d);
        chk("hs_busy_e0", int'(busy), 1);
        chk("hs_valid_e0", int'(dout_valid), 0);
        @(negedge clk);
        chk("hs_busy_e1", int'(busy), 1);
        chk("hs_valid_e1", int'(dout_valid), 0);
        @(negedge clk);
        chk("hs_busy_e2", int'(busy), 1);
        chk("hs_valid_e2", int'(dout_valid), 0);
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        chk("hs_busy_e3", int'(busy), 0);
        chk("hs_valid_e3", int'(dout_valid), 1);
        chk("hs_overrun_set", int'(overrun), 1);
        finish_frame(1'b0, 4'd4, d);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (dout_valid || busy) bad++;
        end
        chk("hs_dropped_frame", bad, 0);
        d = 24'h0A0B0C;
        launch(1'b1, 4'd4, d);
        repeat (3) @(negedge clk);
        chk("hs2_valid_e3", int'(dout_valid), 1);
        finish_frame(1'b1, 4'd4, d);
        d = 24'h203040;
        din = d; sgn = 1'b0; kshift = 4'd4; cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        chk("hs_accept_ech1", int'(busy), 1);
        chk("hs_accept_valid", int'(dout_valid), 0);
        finish_frame(1'b0, 4'd4, d);
        chk("overrun_sticky", int'(overrun), 1);

        // clr one edge after a frame starts
        hold = dout;
        launch(1'b0, 4'd4, 24'h111111);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (dout_valid || busy) bad++;
        end
        chk("clr_no_valid", bad, 0);
        chk("clr_dout_hold", int'(dout == hold), 1);
        run_frame(1'b0, 4'd4, {8'd50, 8'd50, 8'd50});
        for (int c = 0; c < 3; c++)
            chk("clr_next_frame", got[c], 50);

        // time-constant sweep on a 0 -> 64 step
        for (int t = 0; t < 3; t++) begin
            k = (t == 0) ? 4'd1 : ((t == 1) ? 4'd4 : 4'd10);
            do_clr();
            hit = -1;
            for (int f = 0; f < ((t == 2) ? 800 : 30); f++) begin
                run_frame(1'b0, k, {8'd64, 8'd64, 8'd64});
                if (f == 0)
                    chk("step_first", got[0], 64);
                if (hit < 0 && got[0] <= 32)
                    hit = f;
                if (t == 2)
                    seq[f] = got[0];
            end
            if (t == 0)
                chk("tc_k1_frames", hit, 1);
            else if (t == 1)
                chk("tc_k4_in_range", int'(hit >= 10 && hit <= 12), 1);
            else
                chk("tc_k10_in_range", int'(hit >= 639 && hit <= 781), 1);
        end
        do_clr();
        for (int f = 0; f < 800; f++) begin
            run_frame(1'b0, 4'd15, {8'd64, 8'd64, 8'd64});
            chk("k15_eq_k10", got[0], seq[f]);
        end

        // randomized frames against the reference model
        do_clr();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0)
                do_clr();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            s = 1'($urandom_range(0, 1));
            k = 4'($urandom_range(0, 15));
            d = 24'($urandom);
            run_frame(s, k, d);
        end

        // asynchronous reset in the middle of a frame
        do_clr();
        run_frame(1'b0, 4'd4, {8'd50, 8'd50, 8'd50});
        launch(1'b0, 4'd4, 24'h445566);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("amid_rst_dout", int'(dout), 0);
        chk("amid_rst_valid", int'(dout_valid), 0);
        chk("amid_rst_busy", int'(busy), 0);
        chk("amid_rst_overrun", int'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (dout_valid || busy) bad++;
        end
        chk("rst_no_valid", bad, 0);
        run_frame(1'b1, 4'd3, 24'hF07F80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jt49_dcrm_mc.md
# jt49_dcrm_mc

Multi-channel, time-multiplexed DC removal filter for the JT49 audio path, replacing one single-channel filter instance per channel. On each sample strobe it latches CH input samples and processes them serially through one shared datapath, one channel per clock. Each channel keeps its own integrator and error-feedback state. Over the single-channel filter it adds:

- selectable signed/unsigned input
- a run-time time constant
- output saturation
- a synchronous state clear
- overrun detection

## Interface

Parameters:

- SW, 8: sample width (input and output).
- CH, 3: channel count, 1..16.
- DW, 10: fractional width of the integrator.

Ports:

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- cen  in  1  sample strobe; one clk wide; frame start.
- din  in  CH*SW  channel n occupies bits [n*SW+SW-1 : n*SW].
- sgn  in  1  1 = din is two's complement; 0 = din is unsigned.
- kshift  in  4  time constant is 2^kshift samples; legal range 1..DW; values above DW behave as DW; 0 behaves as 1.
- clr  in  1  synchronous clear of all channel state.
- dout  out  CH*SW  signed filtered samples, same packing as din.
- dout_valid  out  1  one-clk pulse when all of dout has been updated.
- busy  out  1  high while processing a frame.
- overrun  out  1  sticky; cleared only by rst.

## Operation

- **State machine, IDLE / RUN.**
  - IDLE, cen=1: latch din, sgn and kshift into a sample buffer; cnt=0; go to RUN.
  - RUN: each clk processes channel cnt and increments cnt.
  - After channel CH-1: copy the result buffer to dout, pulse dout_valid, return to IDLE.
- **Per-channel datapath.** State per channel is integ[c] and err[c], each signed, SW+DW+1 bits.
  - x = sign- or zero-extension of din[c] to SW+1 bits, per the latched sgn.
  - exact = integ + err.
  - q = exact >>> DW (arithmetic shift; SW+1 bits).
  - p = x - q, computed at SW+2 bits with no overflow.
  - integ <= integ + (p <<< (DW - k)), where k is the clamped kshift. Wraps modulo 2^(SW+DW+1).
  - err <= exact - (q <<< DW).
  - Result: p saturated to the signed SW-bit range [-2^(SW-1), 2^(SW-1)-1].
- **cen while busy.** The frame is dropped and overrun sets. The buffer, cnt and the in-progress frame are unaffected. busy=1 on the cycle of the cen counts as busy.
- **clr.** Zeroes every integ, err and result entry, forces IDLE and aborts any frame with no dout_valid. dout holds its value. clr has priority over a cen in the same cycle; that cen is ignored and does not set overrun.
- **CH=1.** Frames take a single RUN cycle.

## Timing

- **Reset values.** rst=1 clears everything immediately: dout=0, dout_valid=0, busy=0, overrun=0, state=IDLE, all integ/err/result entries 0.
- **Frame timing.** cen is accepted at edge E0.
  - Channel n is processed at edge E(n+1).
  - dout and dout_valid are registered at edge E(CH).
  - busy is high from after E0 until after E(CH).
  - Latency is CH clks from accepting cen to dout_valid.
- **Back-to-back frames.** A new cen is accepted at E(CH+1) at the earliest; a cen at E(CH) or earlier sets overrun. Minimum cen spacing is CH+1 clks.
- **Output stability.** dout changes only together with dout_valid, or on rst.
- **Mid-frame changes.** kshift and sgn changes after E0 take effect on the next frame.
- **Reset mid-frame.** Aborts the frame; no dout_valid follows the release of rst.

## Test plan

1. **DC removal.** SW=8, CH=3, sgn=0, kshift=4, din={200,200,200} on every frame. Required:
   - First frame: each dout = 127 (saturated).
   - Outputs decay monotonically.
   - After 256 frames: |dout| <= 1 on all channels.
2. **Saturation and sign.** State cleared with clr, sgn=1, din channel 0 = 0x80 (-128), channel 1 = 0x7F. Required: first frame dout = -128 and 127. With sgn=0 and the same codes, dout = 127 and 127.
3. **Channel independence.** Channel 0 = 100 constant, channels 1 and 2 = 0. Required: channels 1 and 2 stay exactly 0 for all frames; channel 0 converges to 0 ±1.
4. **Latency and handshake.** cen at cycle 10. Required:
   - busy high during cycles 11..13.
   - dout_valid high only at cycle 13.
   - cen at cycle 13 sets overrun and produces no second frame.
   - cen at cycle 14 is accepted.
5. **clr and rst mid-frame.**
   - clr asserted at cycle E0+1: no dout_valid; the next frame with din=50 gives dout=50.
   - rst asserted mid-frame: all outputs read 0 within the same cycle.
6. **Time-constant sweep.** kshift = 1, 4, 10 with a 0→64 step. Required:
   - dout reaches <= 32 after ~1, ~11 and ~710 frames respectively (within ±10%).
   - kshift = 15 behaves identically to kshift = 10.
